// File: rtl/gpio_bank_if.sv
// gpio_bank_if: single-cycle register port between the CPU bus and the GPIO bank
interface gpio_bank_if #(
    parameter int NUM_PINS = 28
) ();
    logic                wr_en;
    logic                rd_en;
    logic [3:0]          addr;
    logic [NUM_PINS-1:0] wdata;
    logic [NUM_PINS-1:0] rdata;
    logic                irq;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, irq
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: configurable GPIO bank with synchronised, debounced inputs and edge interrupts
module gpio_bank #(
    parameter int NUM_PINS    = 28,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    gpio_bank_if.slave         bus,
    inout  wire [NUM_PINS-1:0] pins
);
    localparam logic [3:0] A_DIR    = 4'd0;
    localparam logic [3:0] A_OUT    = 4'd1;
    localparam logic [3:0] A_SET    = 4'd2;
    localparam logic [3:0] A_CLR    = 4'd3;
    localparam logic [3:0] A_IN     = 4'd4;
    localparam logic [3:0] A_RISE   = 4'd5;
    localparam logic [3:0] A_FALL   = 4'd6;
    localparam logic [3:0] A_PEND   = 4'd7;
    localparam logic [3:0] A_DEB    = 4'd8;

    logic [NUM_PINS-1:0] dir;
    logic [NUM_PINS-1:0] out;
    logic [NUM_PINS-1:0] rise_en;
    logic [NUM_PINS-1:0] fall_en;
    logic [NUM_PINS-1:0] pend;
    logic [NUM_PINS-1:0] stable;
    logic [NUM_PINS-1:0] stable_nx;
    logic [NUM_PINS-1:0] set_pend;
    logic [NUM_PINS-1:0] clr_pend;
    logic [NUM_PINS-1:0] sync_o;
    logic [NUM_PINS-1:0] rd_mux;
    logic [NUM_PINS-1:0] sync [SYNC_STAGES];
    logic [DB_W-1:0]     cnt [NUM_PINS];
    logic [DB_W-1:0]     cnt_nx [NUM_PINS];
    logic [DB_W-1:0]     lim;
    logic [15:0]         wr_sel;

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign pins[g] = dir[g] ? out[g] : 1'bz;
    end

    assign sync_o = sync[SYNC_STAGES-1];
    assign wr_sel = bus.wr_en ? (16'd1 << bus.addr) : 16'd0;
    assign clr_pend = wr_sel[A_PEND] ? bus.wdata : '0;
    assign set_pend = ~dir & ((rise_en & ~stable & stable_nx) | (fall_en & stable & ~stable_nx));
    assign bus.irq = |pend;

    // synchroniser chain sampling every pad, driven or not, so IN reflects outputs too
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
        end else begin
            sync[0] <= pins;
            for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
        end
    end

    // debounce: accept a new level once it has disagreed with stable for lim+1 edges;
    // >= rather than == keeps a lowered limit from letting a running count wrap
    always_comb begin
        for (int i = 0; i < NUM_PINS; i++) begin
            stable_nx[i] = stable[i];
            cnt_nx[i]    = '0;
            if (sync_o[i] != stable[i]) begin
                if (cnt[i] >= lim) stable_nx[i] = sync_o[i];
                else cnt_nx[i] = cnt[i] + DB_W'(1);
            end
        end
    end

    // debounce state per pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
        end else begin
            stable <= stable_nx;
            for (int i = 0; i < NUM_PINS; i++) cnt[i] <= cnt_nx[i];
        end
    end

    // control registers; a new edge wins over a same-cycle W1C of its pending bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir     <= '0;
            out     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
            lim     <= '0;
        end else begin
            if (wr_sel[A_DIR])  dir     <= bus.wdata;
            if (wr_sel[A_RISE]) rise_en <= bus.wdata;
            if (wr_sel[A_FALL]) fall_en <= bus.wdata;
            if (wr_sel[A_DEB])  lim     <= DB_W'(bus.wdata);
            out  <= wr_sel[A_OUT] ? bus.wdata :
                    wr_sel[A_SET] ? (out | bus.wdata) :
                    wr_sel[A_CLR] ? (out & ~bus.wdata) : out;
            pend <= (pend & ~clr_pend) | set_pend;
        end
    end

    // read mux; write-only and unmapped addresses return zero
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            A_DIR:   rd_mux = dir;
            A_OUT:   rd_mux = out;
            A_IN:    rd_mux = stable;
            A_RISE:  rd_mux = rise_en;
            A_FALL:  rd_mux = fall_en;
            A_PEND:  rd_mux = pend;
            A_DEB:   rd_mux = NUM_PINS'(lim);
            default: rd_mux = '0;
        endcase
    end

    // registered read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.rdata <= '0;
        else if (bus.rd_en) bus.rdata <= rd_mux;
    end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and random checks of gpio_bank against a behavioural model
module tb_gpio_bank;
    localparam int N  = 28;
    localparam int S  = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gpio_bank_if #(.NUM_PINS(N)) bus ();
    wire  [N-1:0] pins;
    logic [N-1:0] ext_val;
    logic [N-1:0] ext_en;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    gpio_bank #(.NUM_PINS(N), .SYNC_STAGES(S), .DB_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pins    (pins)
    );

    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic [N-1:0]  dir_m, out_m, rise_m, fall_m, pend_m, stable_m, rdata_m;
    logic [DW-1:0] lim_m;
    int            run_m [N];
    logic [N-1:0]  hist [$];
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] reg_val(input logic [3:0] a);
        case (a)
            4'd0:    return dir_m;
            4'd1:    return out_m;
            4'd4:    return stable_m;
            4'd5:    return rise_m;
            4'd6:    return fall_m;
            4'd7:    return pend_m;
            4'd8:    return N'(lim_m);
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        dir_m = '0; out_m = '0; rise_m = '0; fall_m = '0;
        pend_m = '0; stable_m = '0; rdata_m = '0; lim_m = '0;
        for (int i = 0; i < N; i++) run_m[i] = 0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back('0);
    endtask

    // one clock edge of the spec: pad value seen S edges later, level accepted after lim+1 disagreeing edges
    task automatic model_edge();
        logic [N-1:0] pad, s, nst, clr;
        pad = (dir_m & out_m) | (~dir_m & ext_val);
        hist.push_back(pad);
        s = hist[0];
        void'(hist.pop_front());
        nst = stable_m;
        for (int i = 0; i < N; i++) begin
            if (s[i] != stable_m[i]) begin
                run_m[i]++;
                if (run_m[i] > int'(lim_m)) begin
                    nst[i] = s[i];
                    run_m[i] = 0;
                end
            end else run_m[i] = 0;
        end
        if (bus.rd_en) rdata_m = reg_val(bus.addr);
        clr = (bus.wr_en && bus.addr == 4'd7) ? bus.wdata : '0;
        for (int i = 0; i < N; i++) begin
            if (pend_m[i] && clr[i]) pend_m[i] = 1'b0;
            if (!dir_m[i] && stable_m[i] != nst[i] && (nst[i] ? rise_m[i] : fall_m[i])) pend_m[i] = 1'b1;
        end
        stable_m = nst;
        if (bus.wr_en) begin
            case (bus.addr)
                4'd0: dir_m = bus.wdata;
                4'd1: out_m = bus.wdata;
                4'd2: out_m = out_m | bus.wdata;
                4'd3: out_m = out_m & ~bus.wdata;
                4'd5: rise_m = bus.wdata;
                4'd6: fall_m = bus.wdata;
                4'd8: lim_m = bus.wdata[DW-1:0];
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_edge();
        ext_en = ~dir_m;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [N-1:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        bus.rd_en = 1'b1; bus.addr = a;
        cyc();
        bus.rd_en = 1'b0;
        check("rdata_model", bus.rdata, rdata_m);
    endtask

    initial begin
        logic [N-1:0] m;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        ext_val = ONES;
        ext_en  = ONES;
        repeat (3) @(negedge clk);
        check("reset_rdata", bus.rdata, 0);
        check("reset_irq", bus.irq, 0);
        check("reset_pins_undriven", pins, ONES);
        reset_n = 1'b1;
        repeat (3) cyc();
        rd(4'd4);
        check("reset_in_ones", bus.rdata, ONES);
        rd(4'd7);
        check("reset_pend_zero", bus.rdata, 0);

        // output path
        ext_val = N'($urandom);
        wr(4'd0, N'(32'hFF));
        wr(4'd2, N'(32'h0F));
        wr(4'd3, N'(32'h03));
        check("out_pins_low", pins[7:0], 32'h0C);
        check("out_pins_high_undriven", pins, {ext_val[N-1:8], 8'h0C});
        rd(4'd1);
        check("out_read", bus.rdata, 32'h0C);
        rd(4'd2);
        check("set_reads_zero", bus.rdata, 0);
        rd(4'd12);
        check("unmapped_reads_zero", bus.rdata, 0);
        bus.rd_en = 1'b1;
        wr(4'd1, N'(32'h33));
        bus.rd_en = 1'b0;
        check("rdwr_old_value", bus.rdata, 32'h0C);
        check("rdwr_new_pins", pins[7:0], 32'h33);
        wr(4'd0, '0);

        // rising interrupt with L = 0
        ext_val = '0;
        repeat (6) cyc();
        wr(4'd5, N'(32'h20));
        ext_val[5] = 1'b1;
        cyc(); cyc();
        check("rise_irq_early", bus.irq, 0);
        cyc();
        check("rise_irq_set", bus.irq, 1);
        rd(4'd7);
        check("rise_pend", bus.rdata, 32'h20);
        wr(4'd7, N'(32'h20));
        check("w1c_irq_clear", bus.irq, 0);

        // debounce with L = 4
        wr(4'd8, N'(32'hFFFFF04));
        rd(4'd8);
        check("deb_read_zext", bus.rdata, 32'h04);
        wr(4'd6, N'(32'h08));
        ext_val[3] = 1'b1;
        repeat (4) cyc();
        ext_val[3] = 1'b0;
        repeat (10) cyc();
        rd(4'd4);
        check("glitch_in", bus.rdata, 32'h20);
        check("glitch_irq", bus.irq, 0);
        ext_val[3] = 1'b1;
        repeat (6) cyc();
        ext_val[3] = 1'b0;
        rd(4'd4);
        check("deb_in_before", bus.rdata, 32'h20);
        rd(4'd4);
        check("deb_in_after", bus.rdata, 32'h28);
        repeat (4) cyc();
        check("fall_irq_early", bus.irq, 0);
        cyc();
        check("fall_irq_set", bus.irq, 1);
        rd(4'd7);
        check("fall_pend", bus.rdata, 32'h08);
        wr(4'd7, N'(32'h08));
        wr(4'd8, '0);
        wr(4'd6, '0);

        // W1C colliding with a new falling edge
        wr(4'd6, N'(32'h02));
        ext_val[1] = 1'b1;
        repeat (4) cyc();
        ext_val[1] = 1'b0;
        repeat (3) cyc();
        check("coll_first_irq", bus.irq, 1);
        ext_val[1] = 1'b1;
        repeat (4) cyc();
        ext_val[1] = 1'b0;
        cyc(); cyc();
        wr(4'd7, N'(32'h02));
        check("coll_irq_held", bus.irq, 1);
        rd(4'd7);
        check("coll_pend", bus.rdata, 32'h02);
        wr(4'd7, N'(32'h02));
        check("coll_cleared", bus.irq, 0);
        wr(4'd6, '0);

        // output pin edges never pend
        wr(4'd0, N'(32'h04));
        wr(4'd5, N'(32'h24));
        wr(4'd2, N'(32'h04));
        cyc(); cyc();
        rd(4'd4);
        check("outpin_in_before", bus.rdata, 32'h20);
        rd(4'd4);
        check("outpin_in_after", bus.rdata, 32'h24);
        wr(4'd3, N'(32'h04));
        repeat (4) cyc();
        check("outpin_irq", bus.irq, 0);
        rd(4'd7);
        check("outpin_pend", bus.rdata, 0);
        wr(4'd0, '0);
        wr(4'd5, '0);

        // random traffic against the model
        wr(4'd8, N'(32'h2));
        for (int t = 0; t < 1500; t++) begin
            m = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) m[i] = 1'b1;
            ext_val = ext_val ^ m;
            bus.wr_en = ($urandom_range(7) == 0);
            bus.rd_en = ($urandom_range(3) == 0);
            bus.addr  = 4'($urandom_range(11));
            bus.wdata = (bus.addr == 4'd8) ? N'($urandom_range(5)) : N'($urandom);
            cyc();
            check("rand_irq", bus.irq, |pend_m);
            check("rand_rdata", bus.rdata, rdata_m);
            check("rand_pins_driven", pins & dir_m, out_m & dir_m);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        wr(4'd5, ONES);
        wr(4'd6, ONES);
        wr(4'd0, '0);
        ext_val = ~ext_val;
        repeat (8) cyc();
        check("pre_reset_irq", bus.irq, |pend_m);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_irq", bus.irq, 0);
        check("async_rdata", bus.rdata, 0);
        ext_en = ONES;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc();
        rd(4'd4);
        check("post_reset_in", bus.rdata, ext_val);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
